// File: rtl/rect_sprite_sequencer_if.sv
// Pixel-write port toward the vga_adapter frame buffer plus the user
// movement/colour controls of the rectangle sprite sequencer.
interface rect_sprite_sequencer_if;
  logic       move_right;
  logic       move_left;
  logic       move_up;
  logic       move_down;
  logic [2:0] fg_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  modport master (
    input  move_right, move_left, move_up, move_down, fg_colour,
    output x, y, colour, plot, busy, frame_done
  );

  modport slave (
    output move_right, move_left, move_up, move_down, fg_colour,
    input  x, y, colour, plot, busy, frame_done
  );
endinterface

// File: rtl/rect_sprite_sequencer.sv
// Moves a solid rectangle in the frame buffer: on each movement tick the old
// rectangle is erased to the background colour and redrawn, one pixel per clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no pixel writes; waits for need_draw or a tick that changes pos/colour
// S_ERASE | scans old rectangle (ox,oy) row-major with BG_COLOUR
// S_DRAW  | scans current rectangle (px,py) row-major with colour_l
module rect_sprite_sequencer #(
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter int          RECT_W    = 26,
  parameter int          RECT_H    = 16,
  parameter int          X_INIT    = 80,
  parameter int          Y_INIT    = 60,
  parameter int          TICK_DIV  = 100000,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input logic                     clk,
  input logic                     resetn,
  rect_sprite_sequencer_if.master bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [8:0] X_MAX_S  = 9'(SCREEN_W - RECT_W);
  localparam logic signed [8:0] Y_MAX_S  = 9'(SCREEN_H - RECT_H);
  localparam logic [7:0]        LAST_CX  = 8'(RECT_W - 1);
  localparam logic [6:0]        LAST_CY  = 7'(RECT_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [7:0]       px, ox, cx, base_x, nx;
  logic [6:0]       py, oy, cy, base_y, ny;
  logic [2:0]       colour_l;
  logic             need_draw;
  logic signed [8:0] nx_s, ny_s;

  logic [7:0] x_r;
  logic [6:0] y_r;
  logic [2:0] colour_r;
  logic       plot_r, busy_r, frame_done_r;

  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.colour     = colour_r;
  assign bus.plot       = plot_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // Signed 9-bit step so that stepping left/up from 0 goes negative and clamps.
  always_comb begin
    nx_s = $signed({1'b0, px});
    if (bus.move_right && !bus.move_left)      nx_s = nx_s + 9'sd1;
    else if (bus.move_left && !bus.move_right) nx_s = nx_s - 9'sd1;
    ny_s = $signed({2'b00, py});
    if (bus.move_down && !bus.move_up)         ny_s = ny_s + 9'sd1;
    else if (bus.move_up && !bus.move_down)    ny_s = ny_s - 9'sd1;

    if (nx_s < 9'sd0)         nx = 8'd0;
    else if (nx_s > X_MAX_S)  nx = X_MAX_S[7:0];
    else                      nx = nx_s[7:0];
    if (ny_s < 9'sd0)         ny = 7'd0;
    else if (ny_s > Y_MAX_S)  ny = Y_MAX_S[6:0];
    else                      ny = ny_s[6:0];
  end

  assign base_x = (state == S_ERASE) ? ox : px;
  assign base_y = (state == S_ERASE) ? oy : py;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      px           <= 8'(X_INIT);
      py           <= 7'(Y_INIT);
      ox           <= '0;
      oy           <= '0;
      cx           <= '0;
      cy           <= '0;
      colour_l     <= '0;
      need_draw    <= 1'b1;
      x_r          <= '0;
      y_r          <= '0;
      colour_r     <= '0;
      plot_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          plot_r <= 1'b0;
          busy_r <= 1'b0;
          if (need_draw) begin
            need_draw <= 1'b0;
            colour_l  <= bus.fg_colour;
            state     <= S_DRAW;
            cx        <= '0;
            cy        <= '0;
            x_r       <= px;
            y_r       <= py;
            colour_r  <= bus.fg_colour;
            plot_r    <= 1'b1;
            busy_r    <= 1'b1;
          end else if (tick) begin
            colour_l <= bus.fg_colour;
            if (nx != px || ny != py || bus.fg_colour != colour_l) begin
              ox       <= px;
              oy       <= py;
              px       <= nx;
              py       <= ny;
              state    <= S_ERASE;
              cx       <= '0;
              cy       <= '0;
              x_r      <= px;
              y_r      <= py;
              colour_r <= BG_COLOUR;
              plot_r   <= 1'b1;
              busy_r   <= 1'b1;
            end
          end
        end
        S_ERASE, S_DRAW: begin
          if (cx == LAST_CX && cy == LAST_CY) begin
            cx <= '0;
            cy <= '0;
            if (state == S_ERASE) begin
              // Back-to-back into the draw pass: its first pixel goes out now.
              state    <= S_DRAW;
              x_r      <= px;
              y_r      <= py;
              colour_r <= colour_l;
            end else begin
              state        <= S_IDLE;
              plot_r       <= 1'b0;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
            end
          end else if (cx == LAST_CX) begin
            cx  <= '0;
            cy  <= cy + 7'd1;
            x_r <= base_x;
            y_r <= base_y + cy + 7'd1;
          end else begin
            cx  <= cx + 8'd1;
            x_r <= base_x + cx + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_sprite_sequencer.sv
// Bench for rect_sprite_sequencer: two instances (full-size sprite and a tiny
// sprite for fast edge clamping) checked each cycle against an index-based model.
module tb_rect_sprite_sequencer;
  localparam int TD = 8;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn_a, resetn_b;
  rect_sprite_sequencer_if bus_a ();
  rect_sprite_sequencer_if bus_b ();

  rect_sprite_sequencer #(.TICK_DIV(TD)) dut_a (
    .clk(clk), .resetn(resetn_a), .bus(bus_a.master));

  rect_sprite_sequencer #(.RECT_W(4), .RECT_H(2), .X_INIT(2), .Y_INIT(2), .TICK_DIV(TD)) dut_b (
    .clk(clk), .resetn(resetn_b), .bus(bus_b.master));

  int checks = 0;
  int errors = 0;

  int rw[2], rh[2], x0[2], y0[2];
  int cnt[2], px[2], py[2], ox[2], oy[2], col[2], need[2];
  int active[2], k[2], len[2], erase[2];
  int e_x[2], e_y[2], e_c[2], e_plot[2], e_busy[2], e_fd[2], full[2];
  int o_x[2], o_y[2], o_c[2], o_plot[2], o_busy[2], o_fd[2];
  int st_fg[2], st_bg[2], st_xmin[2], st_xmax[2], st_ymin[2], st_ymax[2];
  int st_busy[2], st_fd[2], st_col_or[2], ever_xmax[2], ever_ymax[2];
  string tag[2];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel number j of the current pass: erase pixels first (if any), then draw.
  task automatic emit(int i);
    int n, j;
    n = rw[i] * rh[i];
    if (erase[i] != 0 && k[i] < n) begin
      e_x[i] = ox[i] + k[i] % rw[i];
      e_y[i] = oy[i] + k[i] / rw[i];
      e_c[i] = 0;
    end else begin
      j = (erase[i] != 0) ? k[i] - n : k[i];
      e_x[i] = px[i] + j % rw[i];
      e_y[i] = py[i] + j / rw[i];
      e_c[i] = col[i];
    end
    e_plot[i] = 1;
    e_busy[i] = 1;
  endtask

  task automatic model_step(int i, logic rn, logic mr, logic ml, logic mu, logic md, int fg);
    int t, nx, ny, start;
    if (!rn) begin
      cnt[i] = 0; px[i] = x0[i]; py[i] = y0[i]; need[i] = 1; active[i] = 0; col[i] = 0;
      e_x[i] = 0; e_y[i] = 0; e_c[i] = 0; e_plot[i] = 0; e_busy[i] = 0; e_fd[i] = 0;
      full[i] = 1;
    end else begin
      t = (cnt[i] == TD - 1) ? 1 : 0;
      cnt[i] = (t != 0) ? 0 : cnt[i] + 1;
      full[i] = 0;
      e_fd[i] = 0;
      if (active[i] != 0) begin
        k[i]++;
        if (k[i] == len[i]) begin
          active[i] = 0; e_plot[i] = 0; e_busy[i] = 0; e_fd[i] = 1;
        end else emit(i);
      end else begin
        start = 0;
        if (need[i] != 0) begin
          need[i] = 0; col[i] = fg; erase[i] = 0; len[i] = rw[i] * rh[i]; start = 1;
        end else if (t != 0) begin
          nx = px[i] + ((mr && !ml) ? 1 : 0) - ((ml && !mr) ? 1 : 0);
          ny = py[i] + ((md && !mu) ? 1 : 0) - ((mu && !md) ? 1 : 0);
          if (nx < 0) nx = 0;
          if (nx > SW - rw[i]) nx = SW - rw[i];
          if (ny < 0) ny = 0;
          if (ny > SH - rh[i]) ny = SH - rh[i];
          if (nx != px[i] || ny != py[i] || fg != col[i]) begin
            ox[i] = px[i]; oy[i] = py[i]; px[i] = nx; py[i] = ny;
            erase[i] = 1; len[i] = 2 * rw[i] * rh[i]; start = 1;
          end
          col[i] = fg;
        end
        if (start != 0) begin
          active[i] = 1; k[i] = 0; emit(i);
        end else begin
          e_plot[i] = 0; e_busy[i] = 0;
        end
      end
    end
  endtask

  task automatic clear_stats(int i);
    st_fg[i] = 0; st_bg[i] = 0; st_busy[i] = 0; st_fd[i] = 0; st_col_or[i] = 0;
    st_xmin[i] = 999; st_xmax[i] = -1; st_ymin[i] = 999; st_ymax[i] = -1;
  endtask

  task automatic compare(int i);
    check($sformatf("%s_plot", tag[i]), o_plot[i], e_plot[i]);
    check($sformatf("%s_busy", tag[i]), o_busy[i], e_busy[i]);
    check($sformatf("%s_frame_done", tag[i]), o_fd[i], e_fd[i]);
    if (e_plot[i] != 0 || full[i] != 0) begin
      check($sformatf("%s_x", tag[i]), o_x[i], e_x[i]);
      check($sformatf("%s_y", tag[i]), o_y[i], e_y[i]);
      check($sformatf("%s_colour", tag[i]), o_c[i], e_c[i]);
    end
    if (o_plot[i] != 0) begin
      if (o_x[i] > ever_xmax[i]) ever_xmax[i] = o_x[i];
      if (o_y[i] > ever_ymax[i]) ever_ymax[i] = o_y[i];
      if (o_c[i] == 0) st_bg[i]++;
      else begin
        st_fg[i]++;
        st_col_or[i] |= o_c[i];
        if (o_x[i] < st_xmin[i]) st_xmin[i] = o_x[i];
        if (o_x[i] > st_xmax[i]) st_xmax[i] = o_x[i];
        if (o_y[i] < st_ymin[i]) st_ymin[i] = o_y[i];
        if (o_y[i] > st_ymax[i]) st_ymax[i] = o_y[i];
      end
    end
    if (o_busy[i] != 0) st_busy[i]++;
    if (o_fd[i] != 0) st_fd[i]++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0, resetn_a, bus_a.move_right, bus_a.move_left, bus_a.move_up, bus_a.move_down,
               int'(bus_a.fg_colour));
    model_step(1, resetn_b, bus_b.move_right, bus_b.move_left, bus_b.move_up, bus_b.move_down,
               int'(bus_b.fg_colour));
    @(negedge clk);
    o_x[0] = bus_a.x; o_y[0] = bus_a.y; o_c[0] = bus_a.colour;
    o_plot[0] = bus_a.plot; o_busy[0] = bus_a.busy; o_fd[0] = bus_a.frame_done;
    o_x[1] = bus_b.x; o_y[1] = bus_b.y; o_c[1] = bus_b.colour;
    o_plot[1] = bus_b.plot; o_busy[1] = bus_b.busy; o_fd[1] = bus_b.frame_done;
    compare(0);
    compare(1);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic wait_fd(int i, int max);
    int n = 0;
    while (o_fd[i] == 0 && n < max) begin cyc(); n++; end
    check($sformatf("%s_wait_frame_done_timeout", tag[i]), o_fd[i], 1);
  endtask

  task automatic wait_busy(int i, int max);
    int n = 0;
    while (o_busy[i] == 0 && n < max) begin cyc(); n++; end
    check($sformatf("%s_wait_busy_timeout", tag[i]), o_busy[i], 1);
  endtask

  initial begin
    rw = '{26, 4}; rh = '{16, 2}; x0 = '{80, 2}; y0 = '{60, 2};
    tag = '{"a", "b"};
    ever_xmax = '{-1, -1}; ever_ymax = '{-1, -1};
    resetn_a = 1'b0; resetn_b = 1'b0;
    bus_a.move_right = 0; bus_a.move_left = 0; bus_a.move_up = 0; bus_a.move_down = 0;
    bus_b.move_right = 0; bus_b.move_left = 0; bus_b.move_up = 0; bus_b.move_down = 0;
    bus_a.fg_colour = 3'b001; bus_b.fg_colour = 3'b010;
    run(3);

    // Initial draw after reset release
    clear_stats(0);
    resetn_a = 1'b1;
    cyc();
    check("a_first_x", o_x[0], 80);
    check("a_first_y", o_y[0], 60);
    check("a_first_plot", o_plot[0], 1);
    wait_fd(0, 500);
    run(20);
    check("a_init_fg", st_fg[0], 416);
    check("a_init_bg", st_bg[0], 0);
    check("a_init_xmin", st_xmin[0], 80);
    check("a_init_xmax", st_xmax[0], 105);
    check("a_init_ymin", st_ymin[0], 60);
    check("a_init_ymax", st_ymax[0], 75);
    check("a_init_fd", st_fd[0], 1);
    check("a_init_busy", st_busy[0], 416);

    // One step right
    clear_stats(0);
    bus_a.move_right = 1;
    wait_busy(0, 20);
    bus_a.move_right = 0;
    wait_fd(0, 1000);
    run(20);
    check("a_right_busy", st_busy[0], 832);
    check("a_right_bg", st_bg[0], 416);
    check("a_right_fg", st_fg[0], 416);
    check("a_right_xmin", st_xmin[0], 81);
    check("a_right_xmax", st_xmax[0], 106);

    // Opposing directions cancel, no pass
    clear_stats(0);
    bus_a.move_right = 1; bus_a.move_left = 1;
    run(40);
    check("a_cancel_busy", st_busy[0], 0);
    bus_a.move_right = 0; bus_a.move_left = 0;

    // Colour-only change, with a tick landing mid-draw while move_down is high
    clear_stats(0);
    bus_a.fg_colour = 3'b100;
    wait_busy(0, 20);
    run(500);
    bus_a.move_down = 1;
    run(30);
    bus_a.move_down = 0;
    wait_fd(0, 1000);
    run(30);
    check("a_colour_busy", st_busy[0], 832);
    check("a_colour_fd", st_fd[0], 1);
    check("a_colour_bg", st_bg[0], 416);
    check("a_colour_value", st_col_or[0], 4);
    check("a_colour_xmin", st_xmin[0], 81);
    check("a_colour_ymin", st_ymin[0], 60);
    check("a_colour_ymax", st_ymax[0], 75);

    // Reset at erase pixel 200
    clear_stats(0);
    bus_a.move_right = 1;
    wait_busy(0, 20);
    bus_a.move_right = 0;
    for (int n = 0; n < 300 && st_bg[0] < 200; n++) cyc();
    check("a_reach_erase_200", st_bg[0], 200);
    resetn_a = 1'b0;
    cyc();
    check("a_abort_plot", o_plot[0], 0);
    check("a_abort_x", o_x[0], 0);
    check("a_abort_busy", o_busy[0], 0);
    resetn_a = 1'b1;
    clear_stats(0);
    cyc();
    check("a_redraw_x", o_x[0], 80);
    check("a_redraw_colour", o_c[0], 4);
    wait_fd(0, 500);
    check("a_redraw_bg", st_bg[0], 0);
    check("a_redraw_fg", st_fg[0], 416);
    check("a_redraw_ymin", st_ymin[0], 60);

    // Randomized traffic on the full-size instance
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(39) == 0) begin
        bus_a.move_right = 1'($urandom_range(1));
        bus_a.move_left  = 1'($urandom_range(1));
        bus_a.move_up    = 1'($urandom_range(1));
        bus_a.move_down  = 1'($urandom_range(1));
        if ($urandom_range(3) == 0) bus_a.fg_colour = 3'($urandom_range(7));
      end
      resetn_a = ($urandom_range(2999) != 0);
      cyc();
    end
    resetn_a = 1'b1;

    // Small instance: left edge, then right/bottom clamps
    resetn_b = 1'b1;
    wait_fd(1, 100);
    clear_stats(1);
    bus_b.move_left = 1;
    run(200);
    check("b_left_fd", st_fd[1], 2);
    check("b_left_xmin", st_xmin[1], 0);
    clear_stats(1);
    run(100);
    check("b_left_sat_busy", st_busy[1], 0);
    bus_b.move_left = 0;
    bus_b.move_right = 1; bus_b.move_down = 1;
    run(5000);
    check("b_edge_xmax", ever_xmax[1], 159);
    check("b_edge_ymax", ever_ymax[1], 119);
    clear_stats(1);
    run(100);
    check("b_edge_sat_busy", st_busy[1], 0);
    bus_b.move_right = 0; bus_b.move_down = 0;

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(15) == 0) begin
        bus_b.move_right = 1'($urandom_range(1));
        bus_b.move_left  = 1'($urandom_range(1));
        bus_b.move_up    = 1'($urandom_range(1));
        bus_b.move_down  = 1'($urandom_range(1));
        if ($urandom_range(3) == 0) bus_b.fg_colour = 3'($urandom_range(7));
      end
      resetn_b = ($urandom_range(999) != 0);
      cyc();
    end
    check("b_never_past_right", (ever_xmax[1] <= 159) ? 1 : 0, 1);
    check("a_never_past_right", (ever_xmax[0] <= 159) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_sprite_sequencer.md
Name: rect_sprite_sequencer

Overview:
- Controller that owns the pixel-write port (x, y, colour, plot) of the 160x120, 3-bit vga_adapter frame buffer.
- Moves a solid rectangle under switch control. On each movement tick it erases the old rectangle to the background colour, then redraws it at the new clamped position, one pixel per clock.
- Replaces free-running full-screen scanning: the frame buffer is only written where pixels change.

Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- RECT_W, 26, rectangle width in pixels
- RECT_H, 16, rectangle height in pixels
- X_INIT, 80, rectangle left-edge column after reset
- Y_INIT, 60, rectangle top-edge row after reset
- TICK_DIV, 100000, clocks per movement tick
- BG_COLOUR, 3'b000, colour used for erase

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  reset
- move_right  in  1  move +1 column per tick while high
- move_left  in  1  move -1 column per tick while high
- move_up  in  1  move -1 row per tick while high
- move_down  in  1  move +1 row per tick while high
- fg_colour  in  3  rectangle colour, sampled at tick
- x  out  8  pixel column to vga_adapter
- y  out  7  pixel row to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  write strobe to vga_adapter
- busy  out  1  high while in ERASE or DRAW
- frame_done  out  1  one-cycle pulse when a DRAW pass completes

Behaviour:
- Reset: resetn, synchronous, active-low.
  - Outputs: x=0, y=0, colour=0, plot=0, busy=0, frame_done=0.
  - Internal: tick counter=0, pos=(X_INIT,Y_INIT), need_draw=1, state=IDLE.
- All outputs are registered. x, y, colour and plot change together. A pixel is written only on a cycle with plot=1.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the one cycle when count==TICK_DIV-1.
  - Counts in every state.
- Position update, computed at tick in IDLE:
  - Horizontal: nx = px+1 if move_right&!move_left; px-1 if move_left&!move_right; else px. Same rule vertically with move_down/move_up.
  - Clamp nx to [0, SCREEN_W-RECT_W]=[0,134] and ny to [0, SCREEN_H-RECT_H]=[0,104]. At a bound, the move saturates; there is no wrap.
  - Arithmetic is done at 9 bits so that px-1 at 0 does not underflow.
- States:
  - IDLE: busy=0, plot=0.
    - If need_draw=1: go to DRAW on the next cycle (no tick needed), latch colour_l=fg_colour, clear need_draw.
    - Else on tick: latch colour_l=fg_colour and compute (nx,ny). If (nx,ny)!=(px,py) or fg_colour!=colour_l, latch old=(px,py), set pos=(nx,ny) and go to ERASE. Otherwise stay in IDLE.
  - ERASE: scans the old rectangle row-major from (ox,oy) to (ox+RECT_W-1, oy+RECT_H-1), one pixel per cycle, plot=1, colour=BG_COLOUR.
    - Takes exactly RECT_W*RECT_H = 416 plot cycles, then goes to DRAW.
    - The erase is repeated even on a colour-only change; this is harmless.
  - DRAW: same scan at (px,py) with colour=colour_l, 416 plot cycles.
    - The cycle after the last pixel: plot=0, frame_done=1, state goes to IDLE.
- Transitions and output timing:
  - ERASE→DRAW is back to back: pixel 415 of the erase is immediately followed by pixel 0 of the draw.
  - The first plot appears the cycle after the tick.
- Ticks during ERASE or DRAW are dropped; they are not queued. Direction inputs are only sampled at tick.
- A resetn low mid-pass aborts the scan on the next clock. Outputs go to reset values and the rectangle is then redrawn at (X_INIT,Y_INIT) without an erase. Leftover pixels in the frame buffer are not cleared.
- busy=1 in every ERASE and DRAW cycle, including the first.

Test Plan (TICK_DIV=8 in bench):
- Release reset → DRAW starts next cycle; 416 plots at x 80..105, y 60..75, colour=fg_colour; frame_done pulses once; no BG plots.
- Hold move_right for 1 tick after the initial draw → ERASE 416 plots at x 80..105 with colour 000, then DRAW at x 81..106; busy high for exactly 832 cycles.
- Force position to 134, hold move_right → no ERASE/DRAW on subsequent ticks; x never exceeds 159. Repeat at x=0 with move_left and y=104 with move_down.
- move_left and move_right both high, fg_colour unchanged → no pass. Then change fg_colour 001→100 → one ERASE+DRAW pass at the same position with colour 100.
- Tick arriving mid-DRAW with move_down high → ignored, with no extra pass until the next tick after IDLE.
- Assert resetn=0 at erase pixel 200 → plot=0 next cycle, all outputs 0. After release, DRAW at (80,60) with no ERASE.
